// File: rtl/index_fifo_fwft_if.sv
// Handshake bundle for index_fifo_fwft.
// Carries write data and the write/pop strobes toward the FIFO. Carries the FWFT head word,
// the empty/full/valid flags and the occupancy count back to the producer and consumer.
// INDEX_FIFO_OVERFLOW_EN adds the overflow/underflow pulse signals.
// Modports:
//   master - producer/consumer side: drives din, wr_en, rd_en
//   slave  - FIFO side: drives dout, empty, full, valid, data_count (+ overflow, underflow)
interface index_fifo_fwft_if #(
  parameter int unsigned DATA_W = 22,
  parameter int unsigned CNT_W  = 9
);
  logic [DATA_W-1:0] din;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              empty;
  logic              full;
  logic              valid;
  logic [CNT_W-1:0]  data_count;
`ifdef INDEX_FIFO_OVERFLOW_EN
  logic              overflow;
  logic              underflow;
`endif

  modport master (
    output din,
    output wr_en,
    output rd_en,
`ifdef INDEX_FIFO_OVERFLOW_EN
    input  overflow,
    input  underflow,
`endif
    input  dout,
    input  empty,
    input  full,
    input  valid,
    input  data_count
  );

  modport slave (
    input  din,
    input  wr_en,
    input  rd_en,
`ifdef INDEX_FIFO_OVERFLOW_EN
    output overflow,
    output underflow,
`endif
    output dout,
    output empty,
    output full,
    output valid,
    output data_count
  );
endinterface

// File: rtl/index_fifo_fwft.sv
// First-word-fall-through FIFO for {pattern index, byte position} words.
// The head word is presented on dout whenever the FIFO is not empty, so the consumer takes it
// in the same cycle it pulses rd_en.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset, wins over wr_en/rd_en
//   bus_io - index_fifo_fwft_if.slave: din, wr_en, rd_en in; dout, empty, full, valid,
//            data_count out
// Optional feature: define INDEX_FIFO_OVERFLOW_EN to get registered one-cycle overflow and
// underflow pulses on the interface. Without it, dropped writes/reads are silent.
module index_fifo_fwft #(
  parameter int unsigned DATA_W = 22,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned CNT_W  = 9
) (
  input logic                clk,
  input logic                rst,
  index_fifo_fwft_if.slave   bus_io
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty, full;
  logic              wr_acc, rd_acc;

  // Flags come straight from the registered count so they never glitch on input changes.
  assign empty = (count_q == '0);
  assign full  = (count_q == FullCnt);

  always_comb begin
    wr_acc   = bus_io.wr_en && !full;
    rd_acc   = bus_io.rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: dout is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= bus_io.din;
  end

  assign bus_io.dout       = empty ? '0 : mem_q[rd_ptr_q];
  assign bus_io.empty      = empty;
  assign bus_io.full       = full;
  assign bus_io.valid      = !empty;
  assign bus_io.data_count = count_q;

`ifdef INDEX_FIFO_OVERFLOW_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= bus_io.wr_en && full;
      underflow_q <= bus_io.rd_en && empty;
    end
  end

  assign bus_io.overflow  = overflow_q;
  assign bus_io.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_index_fifo_fwft.sv
// Self-checking bench for index_fifo_fwft. A queue models FIFO contents: words are pushed when
// a write is driven that the model accepts and popped when a read is driven, and the popped
// value is compared with the dout observed in that cycle.
module tb_index_fifo_fwft;
  localparam int unsigned DATA_W = 22;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned CNT_W  = 9;

  logic clk = 1'b0;
  logic rst;

  index_fifo_fwft_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) fifo_if ();

  index_fifo_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (fifo_if.slave)
  );

  always #5 clk = ~clk;

  int unsigned       n_pass  = 0;
  int unsigned       n_total = 0;
  logic [DATA_W-1:0] sb[$];

  // Drive one cycle; got_o is dout seen before the edge, exp_o the model's head if popped.
  task automatic drive(input logic w, input logic [DATA_W-1:0] d, input logic r,
                       output logic popped_o, output logic [DATA_W-1:0] exp_o,
                       output logic [DATA_W-1:0] got_o);
    int unsigned lvl;
    lvl = sb.size();
    fifo_if.din   = d;
    fifo_if.wr_en = w;
    fifo_if.rd_en = r;
    got_o    = fifo_if.dout;
    exp_o    = '0;
    popped_o = r && (lvl > 0);
    if (popped_o) exp_o = sb.pop_front();
    if (w && (lvl < DEPTH)) sb.push_back(d);
    @(posedge clk); #1;
    fifo_if.wr_en = 1'b0;
    fifo_if.rd_en = 1'b0;
    fifo_if.din   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fifo_if.din   = 22'h155;
    fifo_if.wr_en = 1'b1;
    fifo_if.rd_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    fifo_if.wr_en = 1'b0;
    fifo_if.rd_en = 1'b0;
    fifo_if.din   = '0;
    @(posedge clk); #1;
    sb.delete();
    n_total++; if (fifo_if.empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", fifo_if.empty); else n_pass++;
    n_total++; if (fifo_if.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", fifo_if.valid); else n_pass++;
    n_total++; if (fifo_if.full !== 1'b0) $display("FAIL reset_full: got %b want 0", fifo_if.full); else n_pass++;
    n_total++; if (fifo_if.data_count !== 9'd0) $display("FAIL reset_count: got %0d want 0", fifo_if.data_count); else n_pass++;
    n_total++; if (fifo_if.dout !== 22'h0) $display("FAIL reset_dout: got %h want 0", fifo_if.dout); else n_pass++;
`ifdef INDEX_FIFO_OVERFLOW_EN
    n_total++; if (fifo_if.overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", fifo_if.overflow); else n_pass++;
    n_total++; if (fifo_if.underflow !== 1'b0) $display("FAIL reset_underflow: got %b want 0", fifo_if.underflow); else n_pass++;
`endif
  endtask

  task automatic test_single();
    logic p;
    logic [DATA_W-1:0] e, g;
    drive(1'b1, 22'h2A00D, 1'b0, p, e, g);
    n_total++; if (fifo_if.dout !== 22'h2A00D) $display("FAIL single_dout: got %h want 2a00d", fifo_if.dout); else n_pass++;
    n_total++; if (fifo_if.valid !== 1'b1) $display("FAIL single_valid: got %b want 1", fifo_if.valid); else n_pass++;
    n_total++; if (fifo_if.data_count !== 9'd1) $display("FAIL single_count: got %0d want 1", fifo_if.data_count); else n_pass++;
    drive(1'b0, '0, 1'b1, p, e, g);
    n_total++; if (g !== 22'h2A00D) $display("FAIL single_pop: got %h want 2a00d", g); else n_pass++;
    n_total++; if (fifo_if.empty !== 1'b1) $display("FAIL single_empty: got %b want 1", fifo_if.empty); else n_pass++;
    n_total++; if (fifo_if.dout !== 22'h0) $display("FAIL single_dout_empty: got %h want 0", fifo_if.dout); else n_pass++;
  endtask

  task automatic test_fill_drain();
    logic p;
    logic [DATA_W-1:0] e, g;
    for (int i = 0; i < int'(DEPTH); i++) drive(1'b1, DATA_W'(i), 1'b0, p, e, g);
    n_total++; if (fifo_if.full !== 1'b1) $display("FAIL fill_full: got %b want 1", fifo_if.full); else n_pass++;
    n_total++; if (fifo_if.data_count !== 9'd256) $display("FAIL fill_count: got %0d want 256", fifo_if.data_count); else n_pass++;
    drive(1'b1, 22'h3FFFFF, 1'b0, p, e, g);
    n_total++; if (fifo_if.data_count !== 9'd256) $display("FAIL drop_count: got %0d want 256", fifo_if.data_count); else n_pass++;
`ifdef INDEX_FIFO_OVERFLOW_EN
    n_total++; if (fifo_if.overflow !== 1'b1) $display("FAIL overflow_pulse: got %b want 1", fifo_if.overflow); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (fifo_if.overflow !== 1'b0) $display("FAIL overflow_clear: got %b want 0", fifo_if.overflow); else n_pass++;
`endif
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive(1'b0, '0, 1'b1, p, e, g);
      n_total++; if (g !== DATA_W'(i)) $display("FAIL drain_word %0d: got %h want %h", i, g, DATA_W'(i)); else n_pass++;
    end
    n_total++; if (fifo_if.empty !== 1'b1) $display("FAIL drain_empty: got %b want 1", fifo_if.empty); else n_pass++;
    // Refill, then write+pop while full: pop goes through, write is dropped.
    for (int i = 0; i < int'(DEPTH); i++) drive(1'b1, DATA_W'(i + 256), 1'b0, p, e, g);
    drive(1'b1, 22'h3FFFFF, 1'b1, p, e, g);
    n_total++; if (g !== 22'h100) $display("FAIL fullrw_head: got %h want 100", g); else n_pass++;
    n_total++; if (fifo_if.data_count !== 9'd255) $display("FAIL fullrw_count: got %0d want 255", fifo_if.data_count); else n_pass++;
    n_total++; if (fifo_if.full !== 1'b0) $display("FAIL fullrw_full: got %b want 0", fifo_if.full); else n_pass++;
    while (sb.size() > 0) begin
      drive(1'b0, '0, 1'b1, p, e, g);
      n_total++; if (g !== e) $display("FAIL redrain_word: got %h want %h", g, e); else n_pass++;
    end
    n_total++; if (fifo_if.empty !== 1'b1) $display("FAIL redrain_empty: got %b want 1", fifo_if.empty); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic p;
    logic [DATA_W-1:0] e, g;
    drive(1'b1, 22'h12345, 1'b0, p, e, g);
    drive(1'b1, 22'h2ABCD, 1'b1, p, e, g);
    n_total++; if (g !== 22'h12345) $display("FAIL simul_pop: got %h want 12345", g); else n_pass++;
    n_total++; if (fifo_if.dout !== 22'h2ABCD) $display("FAIL simul_head: got %h want 2abcd", fifo_if.dout); else n_pass++;
    n_total++; if (fifo_if.data_count !== 9'd1) $display("FAIL simul_count: got %0d want 1", fifo_if.data_count); else n_pass++;
    n_total++; if (fifo_if.empty !== 1'b0) $display("FAIL simul_empty: got %b want 0", fifo_if.empty); else n_pass++;
    drive(1'b0, '0, 1'b1, p, e, g);
    n_total++; if (g !== e) $display("FAIL simul_last: got %h want %h", g, e); else n_pass++;
  endtask

  task automatic test_underflow();
    logic p;
    logic [DATA_W-1:0] e, g;
    drive(1'b0, '0, 1'b1, p, e, g);
    n_total++; if (fifo_if.data_count !== 9'd0) $display("FAIL under_count: got %0d want 0", fifo_if.data_count); else n_pass++;
    n_total++; if (fifo_if.empty !== 1'b1) $display("FAIL under_empty: got %b want 1", fifo_if.empty); else n_pass++;
    n_total++; if (fifo_if.dout !== 22'h0) $display("FAIL under_dout: got %h want 0", fifo_if.dout); else n_pass++;
`ifdef INDEX_FIFO_OVERFLOW_EN
    n_total++; if (fifo_if.underflow !== 1'b1) $display("FAIL underflow_pulse: got %b want 1", fifo_if.underflow); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (fifo_if.underflow !== 1'b0) $display("FAIL underflow_clear: got %b want 0", fifo_if.underflow); else n_pass++;
`endif
  endtask

  task automatic test_interleaved();
    logic p, w, r;
    logic [DATA_W-1:0] e, g, d;
    int written = 0;
    int cycles  = 0;
    while (((written < 600) || (sb.size() > 0)) && (cycles < 6000)) begin
      w = (written < 600) && ($urandom_range(0, 3) != 0);
      r = (written < 600) ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 3) != 0);
      d = DATA_W'($urandom);
      if (w && (sb.size() < DEPTH)) written++;
      drive(w, d, r, p, e, g);
      if (p) begin
        n_total++; if (g !== e) $display("FAIL stream_word: got %h want %h", g, e); else n_pass++;
      end
      n_total++; if (fifo_if.data_count !== CNT_W'(sb.size())) $display("FAIL stream_count: got %0d want %0d", fifo_if.data_count, sb.size()); else n_pass++;
      cycles++;
    end
    n_total++; if (sb.size() != 0 || written < 600) $display("FAIL stream_timeout: got %0d left want 0", sb.size()); else n_pass++;
    n_total++; if (fifo_if.empty !== 1'b1) $display("FAIL stream_empty: got %b want 1", fifo_if.empty); else n_pass++;
  endtask

  initial begin
    fifo_if.din   = '0;
    fifo_if.wr_en = 1'b0;
    fifo_if.rd_en = 1'b0;
    rst = 1'b1;
    test_reset();
    test_single();
    test_fill_drain();
    test_simultaneous();
    test_underflow();
    test_interleaved();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
